// File: rtl/xil_mem_sp_be.sv
// xil_mem_sp_be: single-port block RAM with per-byte write enables,
// read-first data, optional output register and optional hardware clear.
//
// Ports:
//   clk      : clock, everything on the rising edge
//   rst      : asynchronous active-high reset
//   i_en     : access request, taken only while o_ready=1
//   i_wen    : byte-lane write enables, bit k covers i_wdata[8k+7:8k]
//   i_adr    : word address
//   i_wdata  : write data
//   o_ready  : block accepts requests (low while clearing)
//   o_rdata  : read data, contents of the word before the access
//   o_rvalid : one-cycle pulse marking fresh o_rdata
module xil_mem_sp_be #(
   parameter int unsigned DATA_BYTES     = 2,
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned OUT_REG        = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en,
   input  logic [DATA_BYTES-1:0]   i_wen,
   input  logic [ADDR_W-1:0]       i_adr,
   input  logic [8*DATA_BYTES-1:0] i_wdata,
   output logic                    o_ready,
   output logic [8*DATA_BYTES-1:0] o_rdata,
   output logic                    o_rvalid
);

   localparam int unsigned DW    = 8 * DATA_BYTES;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_e;

   localparam state_e RST_STATE =
      (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [ADDR_W-1:0] clr_cnt_d;

   // ------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            state_d = S_READY;
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   logic clearing;
   logic acc;

   assign clearing = (state_q == S_CLEAR);
   assign o_ready  = (state_q == S_READY);
   assign acc      = i_en & o_ready;

   // ------------------------------------------------------------
   // Single RAM port shared by the sweep and client accesses.
   // The sweep owns the port while clearing, so no arbitration.
   // ------------------------------------------------------------
   logic [DATA_BYTES-1:0] mem_we;
   logic [ADDR_W-1:0]     mem_adr;
   logic [DW-1:0]         mem_wd;

   always_comb begin
      mem_we  = '0;
      mem_adr = i_adr;
      mem_wd  = i_wdata;
      if (clearing) begin
         mem_we  = '1;
         mem_adr = clr_cnt_q;
         mem_wd  = '0;
      end else if (acc) begin
         mem_we  = i_wen;
      end
   end

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] ram_rd_q;

   // No reset here so the array and its read latch map onto a
   // byte-write BRAM. The read samples the old word because the
   // lane writes are non-blocking (read-first).
   always_ff @(posedge clk) begin
      if (acc) begin
         ram_rd_q <= mem_q[mem_adr];
      end
      for (int k = 0; k < int'(DATA_BYTES); k++) begin
         if (mem_we[k]) begin
            mem_q[mem_adr][8*k +: 8] <= mem_wd[8*k +: 8];
         end
      end
   end

   // ------------------------------------------------------------
   // Read-valid tracking. seen_q masks the un-resettable BRAM
   // latch so o_rdata reads zero from reset until the first read.
   // ------------------------------------------------------------
   logic          rv1_q;
   logic          seen_q;
   logic [DW-1:0] rd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv1_q  <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         rv1_q  <= acc;
         seen_q <= seen_q | acc;
      end
   end

   assign rd1 = ram_rd_q & {DW{seen_q}};

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DW-1:0] out_q;
         logic          rv2_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_q <= '0;
               rv2_q <= 1'b0;
            end else begin
               rv2_q <= rv1_q;
               if (rv1_q) begin
                  out_q <= rd1;
               end
            end
         end

         assign o_rdata  = out_q;
         assign o_rvalid = rv2_q;
      end else begin : g_noreg
         assign o_rdata  = rd1;
         assign o_rvalid = rv1_q;
      end
   endgenerate

endmodule

// File: tb/tb_xil_mem_sp_be.sv
// tb_xil_mem_sp_be: directed bench for xil_mem_sp_be, three
// configurations, scoreboard of expected read results.
module tb_xil_mem_sp_be;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: defaults
   logic        rst_a, en_a, rdy_a, rv_a;
   logic [1:0]  wen_a;
   logic [9:0]  adr_a;
   logic [15:0] wd_a, rd_a;
   // DUT B: OUT_REG=1
   logic        rst_b, en_b, rdy_b, rv_b;
   logic [1:0]  wen_b;
   logic [9:0]  adr_b;
   logic [15:0] wd_b, rd_b;
   // DUT C: no clear, 4 lanes, 16 words
   logic        rst_c, en_c, rdy_c, rv_c;
   logic [3:0]  wen_c;
   logic [3:0]  adr_c;
   logic [31:0] wd_c, rd_c;

   xil_mem_sp_be u_a (
      .clk(clk), .rst(rst_a), .i_en(en_a), .i_wen(wen_a),
      .i_adr(adr_a), .i_wdata(wd_a), .o_ready(rdy_a),
      .o_rdata(rd_a), .o_rvalid(rv_a));

   xil_mem_sp_be #(.OUT_REG(1)) u_b (
      .clk(clk), .rst(rst_b), .i_en(en_b), .i_wen(wen_b),
      .i_adr(adr_b), .i_wdata(wd_b), .o_ready(rdy_b),
      .o_rdata(rd_b), .o_rvalid(rv_b));

   xil_mem_sp_be #(.DATA_BYTES(4), .ADDR_W(4),
                   .CLEAR_ON_RESET(0)) u_c (
      .clk(clk), .rst(rst_c), .i_en(en_c), .i_wen(wen_c),
      .i_adr(adr_c), .i_wdata(wd_c), .o_ready(rdy_c),
      .o_rdata(rd_c), .o_rvalid(rv_c));

   typedef struct {
      logic [31:0] dat;
      int          due;
      bit          care;
   } exp_t;

   exp_t        expq [$];
   logic [31:0] mdl [3][1024];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;

   // output capture, written only by the monitor
   logic [31:0] obs_dat [3][64];
   int          obs_cyc [3][64];
   int          obs_n [3] = '{0, 0, 0};
   int          rd_idx [3] = '{0, 0, 0};

   always @(negedge clk) begin
      if (rv_a && obs_n[0] < 64) begin
         obs_dat[0][obs_n[0]] = {16'h0, rd_a};
         obs_cyc[0][obs_n[0]] = cyc;
         obs_n[0] = obs_n[0] + 1;
      end
      if (rv_b && obs_n[1] < 64) begin
         obs_dat[1][obs_n[1]] = {16'h0, rd_b};
         obs_cyc[1][obs_n[1]] = cyc;
         obs_n[1] = obs_n[1] + 1;
      end
      if (rv_c && obs_n[2] < 64) begin
         obs_dat[2][obs_n[2]] = rd_c;
         obs_cyc[2][obs_n[2]] = cyc;
         obs_n[2] = obs_n[2] + 1;
      end
   end

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(int d);
      case (d)
         0:       return rdy_a;
         1:       return rdy_b;
         default: return rdy_c;
      endcase
   endfunction

   task automatic set_en(int d, logic v);
      case (d)
         0:       en_a = v;
         1:       en_b = v;
         default: en_c = v;
      endcase
   endtask

   // one access per call, one cycle per call
   task automatic acc(int d, logic [3:0] wen, logic [9:0] adr,
                      logic [31:0] wd, bit care);
      exp_t        e;
      logic [31:0] nw;
      int          nb;
      @(posedge clk);
      #1;
      case (d)
         0: begin
            en_a = 1'b1; wen_a = wen[1:0];
            adr_a = adr; wd_a = wd[15:0];
         end
         1: begin
            en_b = 1'b1; wen_b = wen[1:0];
            adr_b = adr; wd_b = wd[15:0];
         end
         default: begin
            en_c = 1'b1; wen_c = wen;
            adr_c = adr[3:0]; wd_c = wd;
         end
      endcase
      nb     = (d == 2) ? 4 : 2;
      e.dat  = mdl[d][adr];
      e.due  = cyc + 1 + ((d == 1) ? 1 : 0);
      e.care = care;
      expq.push_back(e);
      nw = mdl[d][adr];
      for (int k = 0; k < nb; k++)
         if (wen[k]) nw[8*k +: 8] = wd[8*k +: 8];
      mdl[d][adr] = nw;
   endtask

   task automatic drain(int d, string tag);
      exp_t e;
      int   n;
      @(posedge clk);
      #1;
      set_en(d, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      n = expq.size();
      chk({tag, "_count"}, 32'(obs_n[d] - rd_idx[d]), 32'(n));
      for (int i = 0; i < n; i++) begin
         e = expq.pop_front();
         if (rd_idx[d] < obs_n[d]) begin
            chk($sformatf("%s_cyc%0d", tag, i),
                32'(obs_cyc[d][rd_idx[d]]), 32'(e.due));
            if (e.care)
               chk($sformatf("%s_dat%0d", tag, i),
                   obs_dat[d][rd_idx[d]], e.dat);
            rd_idx[d]++;
         end
      end
      rd_idx[d] = obs_n[d];
   endtask

   // call right after rst release at posedge+#1
   task automatic clr_wait(int d, string tag);
      int c0;
      int n;
      c0 = cyc;
      n  = 0;
      while (!rdy(d) && n < 1100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(cyc - c0), 32'd1024);
   endtask

   task automatic zero_mdl(int d);
      for (int i = 0; i < 1024; i++) mdl[d][i] = '0;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      en_a = 1'b0; wen_a = '0; adr_a = '0; wd_a = '0;
      en_b = 1'b0; wen_b = '0; adr_b = '0; wd_b = '0;
      en_c = 1'b0; wen_c = '0; adr_c = '0; wd_c = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy_a", 32'(rdy_a), 32'd0);
      chk("rst_rv_a", 32'(rv_a), 32'd0);
      chk("rst_rd_a", {16'h0, rd_a}, 32'h0);
      chk("rst_rdy_c", 32'(rdy_c), 32'd1);

      // clear with a request held on the port
      en_a = 1'b1; adr_a = 10'd5;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      clr_wait(0, "clear1_len");
      en_a = 1'b0;
      zero_mdl(0);
      acc(0, 4'b0000, 10'h000, 32'h0, 1'b1);
      acc(0, 4'b0000, 10'h3FF, 32'h0, 1'b1);
      drain(0, "clear1_rd");

      // byte lanes
      acc(0, 4'b0011, 10'h3FF, 32'hBEEF, 1'b1);
      acc(0, 4'b0001, 10'h3FF, 32'h1234, 1'b1);
      acc(0, 4'b0000, 10'h3FF, 32'h0, 1'b1);
      drain(0, "lanes");

      // read-first, back to back
      acc(0, 4'b0011, 10'h010, 32'hAAAA, 1'b1);
      acc(0, 4'b0000, 10'h010, 32'h0, 1'b1);
      acc(0, 4'b0011, 10'h010, 32'h5555, 1'b1);
      acc(0, 4'b0000, 10'h010, 32'h0, 1'b1);
      drain(0, "b2b_a");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("hold_rd_a", {16'h0, rd_a}, 32'h5555);
      chk("hold_rv_a", 32'(rv_a), 32'd0);

      // reset with held data, then reset again mid-clear
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      #1;
      chk("arst_rd_a", {16'h0, rd_a}, 32'h0);
      chk("arst_rdy_a", 32'(rdy_a), 32'd0);
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      rst_a = 1'b1;
      #1;
      chk("mid_rdy_a", 32'(rdy_a), 32'd0);
      chk("mid_rv_a", 32'(rv_a), 32'd0);
      chk("mid_rd_a", {16'h0, rd_a}, 32'h0);
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      clr_wait(0, "clear2_len");
      zero_mdl(0);
      acc(0, 4'b0000, 10'h010, 32'h0, 1'b1);
      acc(0, 4'b0000, 10'h3FF, 32'h0, 1'b1);
      drain(0, "clear2_rd");

      // OUT_REG=1
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      clr_wait(1, "clear_b_len");
      zero_mdl(1);
      acc(1, 4'b0011, 10'h010, 32'hAAAA, 1'b1);
      acc(1, 4'b0000, 10'h010, 32'h0, 1'b1);
      acc(1, 4'b0011, 10'h010, 32'h5555, 1'b1);
      acc(1, 4'b0000, 10'h010, 32'h0, 1'b1);
      drain(1, "b2b_b");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("hold_rd_b", {16'h0, rd_b}, 32'h5555);
      chk("hold_rv_b", 32'(rv_b), 32'd0);

      // no clear, wide lanes
      @(posedge clk);
      #1;
      rst_c = 1'b0;
      #1;
      chk("rdy_c_now", 32'(rdy_c), 32'd1);
      acc(2, 4'b1111, 10'd15, 32'h01234567, 1'b0);
      acc(2, 4'b1010, 10'd15, 32'hDEADBEEF, 1'b1);
      acc(2, 4'b0000, 10'd15, 32'hFFFFFFFF, 1'b1);
      acc(2, 4'b0000, 10'd15, 32'h0, 1'b1);
      drain(2, "lanes_c");
      chk("lanes_c_final", rd_c, 32'hDE23BE67);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
